// File: rtl/synth_pkg.sv
// synth_pkg: shared types and the note-to-increment table for the sawtooth oscillator.
//   osc_state_t  : oscillator state machine encoding (IDLE, PLAY, FINISH)
//   NOTE_NONE    : note code meaning "no note"
//   NOTE_MAX     : highest valid note code (C5)
//   note_to_inc  : 16-bit phase increment for a note code (0 for invalid codes)
//   note_valid   : true for codes 1..NOTE_MAX
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FINISH = 2'd2
  } osc_state_t;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_MAX  = 4'd13;

  // round(f * 2^16 / 10 kHz) for C4..C5, equal temperament with A4 = 440 Hz.
  function automatic logic [15:0] note_to_inc(input logic [3:0] note);
    case (note)
      4'd1:    return 16'd1715;  // C4
      4'd2:    return 16'd1817;  // C#4
      4'd3:    return 16'd1925;  // D4
      4'd4:    return 16'd2039;  // D#4
      4'd5:    return 16'd2160;  // E4
      4'd6:    return 16'd2289;  // F4
      4'd7:    return 16'd2425;  // F#4
      4'd8:    return 16'd2569;  // G4
      4'd9:    return 16'd2722;  // G#4
      4'd10:   return 16'd2884;  // A4
      4'd11:   return 16'd3055;  // A#4
      4'd12:   return 16'd3237;  // B4
      4'd13:   return 16'd3429;  // C5
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic note_valid(input logic [3:0] note);
    return (note != NOTE_NONE) && (note <= NOTE_MAX);
  endfunction

endpackage

// File: rtl/sample_clk_div.sv
// sample_clk_div: free-running prescaler producing the internal sample tick.
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   tick  : high for the one cycle in which the count equals CLK_DIV-1
// The first tick after reset falls in cycle CLK_DIV.
module sample_clk_div #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic n_rst,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/saw_oscillator.sv
// saw_oscillator: phase-accumulator sawtooth oscillator with click-free release.
//   clk         : system clock
//   n_rst       : asynchronous active-low reset
//   note_in     : 0 = no note, 1..13 = C4..C5, 14/15 treated as no note
//   saw_out     : top 8 bits of the phase accumulator
//   sample_tick : one-cycle pulse in the first cycle saw_out holds a new sample
//   wrap        : one-cycle pulse with sample_tick when the accumulator overflowed
//   active      : high whenever the oscillator is not IDLE
// Optional feature: define SAW_OSC_GLIDE_EN for portamento, where the increment
// slews toward the target by at most GLIDE_STEP per tick.
module saw_oscillator
  import synth_pkg::*;
#(
  parameter int CLK_DIV    = 1000,
  parameter int ACC_W      = 16,
  parameter int GLIDE_STEP = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] note_in,
  output logic [7:0] saw_out,
  output logic       sample_tick,
  output logic       wrap,
  output logic       active
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("saw_oscillator: CLK_DIV must be at least 2");
  end
  if (ACC_W < 8) begin : g_bad_acc_w
    $error("saw_oscillator: ACC_W must be at least 8");
  end
  if (GLIDE_STEP < 1) begin : g_bad_glide
    $error("saw_oscillator: GLIDE_STEP must be at least 1");
  end

  // Table entries are for a 16-bit accumulator; rescale by 2^(ACC_W-16)
  // in either direction.
  function automatic logic [ACC_W-1:0] scale_inc(input logic [15:0] v);
    logic [ACC_W+15:0] w;
    w = {{ACC_W{1'b0}}, v} << ACC_W;
    return w[ACC_W+15:16];
  endfunction

  logic             tick;
  osc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] inc_next;
  logic [ACC_W-1:0] tbl_inc;
  logic [ACC_W:0]   sum;
  logic             note_ok;

  sample_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .n_rst(n_rst),
    .tick (tick)
  );

  assign note_ok = note_valid(note_in);
  assign tbl_inc = scale_inc(note_to_inc(note_in));
  // Carry out of the extra bit is the overflow flag.
  assign sum     = {1'b0, acc} + {1'b0, inc};

`ifdef SAW_OSC_GLIDE_EN
  logic [ACC_W-1:0] target;

  function automatic logic [ACC_W-1:0] glide_toward(input logic [ACC_W-1:0] cur,
                                                    input logic [ACC_W-1:0] tgt);
    logic [ACC_W-1:0] dist;
    logic [ACC_W-1:0] step;
    step = ACC_W'(GLIDE_STEP);
    if (cur < tgt) begin
      dist = tgt - cur;
      return cur + ((dist > step) ? step : dist);
    end else begin
      dist = cur - tgt;
      return cur - ((dist > step) ? step : dist);
    end
  endfunction

  // With no note the glide keeps heading for the last latched target.
  assign inc_next = glide_toward(inc, note_ok ? tbl_inc : target);
`else
  assign inc_next = note_ok ? tbl_inc : inc;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      acc         <= '0;
      inc         <= '0;
      sample_tick <= 1'b0;
      wrap        <= 1'b0;
`ifdef SAW_OSC_GLIDE_EN
      target      <= '0;
`endif
    end else begin
      sample_tick <= tick;
      wrap        <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            acc <= '0;
            if (note_ok) begin
              // Start from phase zero; first accumulation is on the next tick.
              state <= PLAY;
              inc   <= tbl_inc;
`ifdef SAW_OSC_GLIDE_EN
              target <= tbl_inc;
`endif
            end
          end
          PLAY: begin
            acc  <= sum[ACC_W-1:0];
            wrap <= sum[ACC_W];
            inc  <= inc_next;
`ifdef SAW_OSC_GLIDE_EN
            if (note_ok) target <= tbl_inc;
`endif
            if (!note_ok) state <= FINISH;
          end
          FINISH: begin
            if (note_ok) begin
              // Retrigger keeps the phase running so there is no discontinuity.
              acc   <= sum[ACC_W-1:0];
              wrap  <= sum[ACC_W];
              inc   <= inc_next;
              state <= PLAY;
`ifdef SAW_OSC_GLIDE_EN
              target <= tbl_inc;
`endif
            end else if (sum[ACC_W]) begin
              // Land exactly on zero rather than the residue to avoid a click.
              acc   <= '0;
              wrap  <= 1'b1;
              state <= IDLE;
            end else begin
              acc <= sum[ACC_W-1:0];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign saw_out = acc[ACC_W-1 -: 8];
  assign active  = (state != IDLE);

endmodule

// File: tb/tb_saw_oscillator.sv
// tb_saw_oscillator: scoreboard bench for saw_oscillator with CLK_DIV=4, ACC_W=16.
// Stimulus issues one note code per sample tick and pushes the expected
// (saw_out, wrap, active) triple; a monitor pops on every sample_tick.
module tb_saw_oscillator;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic [7:0] saw_out;
  logic       sample_tick;
  logic       wrap;
  logic       active;

  saw_oscillator #(
    .CLK_DIV   (4),
    .ACC_W     (16),
    .GLIDE_STEP(4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .note_in    (note_in),
    .saw_out    (saw_out),
    .sample_tick(sample_tick),
    .wrap       (wrap),
    .active     (active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] saw;
    logic       wrp;
    logic       act;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: 0 = IDLE, 1 = PLAY, 2 = FINISH
  int m_st  = 0;
  int m_acc = 0;
  int m_inc = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int tbl(input int n);
    case (n)
      1: return 1715;  2: return 1817;  3: return 1925;  4: return 2039;
      5: return 2160;  6: return 2289;  7: return 2425;  8: return 2569;
      9: return 2722; 10: return 2884; 11: return 3055; 12: return 3237;
      13: return 3429;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_acc = 0;
    m_inc = 0;
  endtask

  task automatic model_tick(input int n);
    bit   valid;
    int   s;
    exp_t e;
    valid = (n >= 1) && (n <= 13);
    e.wrp = 1'b0;
    case (m_st)
      0: begin
        m_acc = 0;
        if (valid) begin
          m_st  = 1;
          m_inc = tbl(n);
        end
      end
      1: begin
        s     = m_acc + m_inc;
        e.wrp = (s >= 65536);
        m_acc = s % 65536;
        if (valid) m_inc = tbl(n);
        else       m_st  = 2;
      end
      default: begin
        s = m_acc + m_inc;
        if (valid) begin
          e.wrp = (s >= 65536);
          m_acc = s % 65536;
          m_inc = tbl(n);
          m_st  = 1;
        end else if (s >= 65536) begin
          e.wrp = 1'b1;
          m_acc = 0;
          m_st  = 0;
        end else begin
          m_acc = s;
        end
      end
    endcase
    e.saw = 8'(m_acc >> 8);
    e.act = (m_st != 0);
    sb.push_back(e);
  endtask

  // Present a note for the next tick, record the expectation, and wait
  // (bounded) until the DUT shows that tick's sample.
  task automatic do_tick(input logic [3:0] n);
    bit seen;
    note_in = n;
    model_tick(int'(n));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sample_tick) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: no sample_tick within 20 cycles, expected one every 4");
    end
  endtask

  // Monitor
  int   cyc = 0;
  exp_t got_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        cyc = 0;
      end else begin
        cyc++;
        if (sample_tick) begin
          check("tick_interval", cyc, 4);
          cyc = 0;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: sample_tick with no expected entry (t=%0t)", $time);
          end else begin
            got_e = sb.pop_front();
            check("saw_out", int'(saw_out), int'(got_e.saw));
            check("wrap",    int'(wrap),    int'(got_e.wrp));
            check("active",  int'(active),  int'(got_e.act));
          end
        end else begin
          check("wrap_off_tick", int'(wrap), 0);
        end
      end
    end
  end

  initial begin
    n_rst   = 1'b0;
    note_in = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_saw",  int'(saw_out),     0);
    check("rst_tick", int'(sample_tick), 0);
    check("rst_wrap", int'(wrap),        0);
    check("rst_act",  int'(active),      0);
    @(negedge clk);
    #1 n_rst = 1'b1;
    model_reset();

    // Silence: stays idle at zero.
    for (int k = 0; k < 10; k++) do_tick(4'd0);

    // A4 from idle.
    for (int k = 1; k <= 30; k++) begin
      do_tick(4'd10);
      if (k == 1)  check("a4_active_t1", int'(active), 1);
      if (k == 2)  check("a4_saw_t2", int'(saw_out), 11);
      if (k == 24) begin
        check("a4_wrap_t24", int'(wrap), 1);
        check("a4_saw_t24",  int'(saw_out), 3);
      end
    end

    // Release: ramp runs out to the wrap, then holds at zero.
    for (int k = 0; k < 25; k++) do_tick(4'd0);
    check("release_idle_act", int'(active),  0);
    check("release_idle_saw", int'(saw_out), 0);

    // A4, release, then C5 retrigger from FINISH with phase continuity.
    for (int k = 0; k < 5; k++)  do_tick(4'd10);
    for (int k = 0; k < 3; k++)  do_tick(4'd0);
    check("finish_act", int'(active), 1);
    for (int k = 0; k < 10; k++) do_tick(4'd13);

    // Asynchronous reset between clock edges while playing.
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_saw",  int'(saw_out),     0);
    check("async_rst_tick", int'(sample_tick), 0);
    check("async_rst_wrap", int'(wrap),        0);
    check("async_rst_act",  int'(active),      0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    #1 n_rst = 1'b1;

    // Codes 14 and 15 are not notes.
    for (int k = 0; k < 3; k++) do_tick(4'd14);
    do_tick(4'd15);
    check("invalid_note_idle", int'(active), 0);

    // Power-up behaviour after reset.
    for (int k = 1; k <= 3; k++) begin
      do_tick(4'd10);
      if (k == 2) check("post_rst_saw_t2", int'(saw_out), 11);
    end

    #2;
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
